// File: rtl/relu_stream_act.sv
// Streaming multi-lane activation unit with a two-stage valid/ready pipeline.
// Modes per beat: pass, ReLU, leaky ReLU and clamp. Define ACT_STATS_EN to add the zero_cnt/stats_clr statistics counter.
module relu_stream_act #(
   parameter int DATA_W     = 8,
   parameter int LANES      = 4,
   parameter int LEAK_SHIFT = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES*DATA_W-1:0]   in_data,
   input  logic [1:0]                mode,
   input  logic [DATA_W-1:0]         clamp_val,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [LANES*DATA_W-1:0]   out_data
`ifdef ACT_STATS_EN
   ,
   output logic [15:0]               zero_cnt,
   input  logic                      stats_clr
`endif
);

   localparam int BEAT_W = LANES * DATA_W;

   function automatic logic [DATA_W-1:0] act_lane(
      input logic [DATA_W-1:0] x,
      input logic [1:0]        m,
      input logic [DATA_W-1:0] c
   );
      logic [DATA_W-1:0] y;
      logic              x_neg;
      logic              c_neg;
      x_neg = x[DATA_W-1];
      c_neg = c[DATA_W-1];
      case (m)
         2'b00: y = x;
         2'b01: y = x_neg ? {DATA_W{1'b0}} : x;
         2'b10: y = x_neg ? DATA_W'($signed(x) >>> LEAK_SHIFT) : x;
         2'b11: begin
            if (c_neg || x_neg) begin
               y = {DATA_W{1'b0}};
            end else if ($signed(x) > $signed(c)) begin
               y = c;
            end else begin
               y = x;
            end
         end
         default: y = x;
      endcase
      return y;
   endfunction

   logic              s1_valid_q, s1_valid_d;
   logic [BEAT_W-1:0] s1_data_q,  s1_data_d;
   logic [1:0]        s1_mode_q,  s1_mode_d;
   logic [DATA_W-1:0] s1_clamp_q, s1_clamp_d;
   logic              s2_valid_q, s2_valid_d;
   logic [BEAT_W-1:0] s2_data_q,  s2_data_d;
   logic              s2_load_s;
   logic              s1_load_s;
   logic [BEAT_W-1:0] result_s;

   // Per-lane activation of the beat held in S1.
   always_comb begin
      result_s = {BEAT_W{1'b0}};
      for (int i = 0; i < LANES; i++) begin
         result_s[i*DATA_W +: DATA_W] = act_lane(s1_data_q[i*DATA_W +: DATA_W], s1_mode_q, s1_clamp_q);
      end
   end

   // Stage advance: S2 takes S1 whenever S2 is free or draining; S1 refills in the same cycle.
   always_comb begin
      s2_load_s  = !s2_valid_q || out_ready;
      s1_load_s  = in_valid && (!s1_valid_q || s2_load_s);
      s1_valid_d = (!s1_valid_q || s2_load_s) ? in_valid : s1_valid_q;
      s1_data_d  = s1_load_s ? in_data   : s1_data_q;
      s1_mode_d  = s1_load_s ? mode      : s1_mode_q;
      s1_clamp_d = s1_load_s ? clamp_val : s1_clamp_q;
      s2_valid_d = s2_load_s ? s1_valid_q : s2_valid_q;
      s2_data_d  = (s2_load_s && s1_valid_q) ? result_s : s2_data_q;
   end

   // Pipeline registers; reset discards any buffered beats.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= {BEAT_W{1'b0}};
         s1_mode_q  <= 2'b00;
         s1_clamp_q <= {DATA_W{1'b0}};
         s2_valid_q <= 1'b0;
         s2_data_q  <= {BEAT_W{1'b0}};
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         s1_mode_q  <= s1_mode_d;
         s1_clamp_q <= s1_clamp_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
      end
   end

   assign in_ready  = !s1_valid_q || s2_load_s;
   assign out_valid = s2_valid_q;
   assign out_data  = s2_data_q;

`ifdef ACT_STATS_EN
   logic [15:0] zero_cnt_q, zero_cnt_d;
   logic [15:0] zeros_s;
   logic [16:0] sum_s;

   // Saturating zero-lane counter; clear beats a same-cycle increment.
   always_comb begin
      zeros_s = 16'd0;
      for (int i = 0; i < LANES; i++) begin
         if (s2_data_q[i*DATA_W +: DATA_W] == {DATA_W{1'b0}}) begin
            zeros_s = zeros_s + 16'd1;
         end else begin
            zeros_s = zeros_s;
         end
      end
      sum_s = {1'b0, zero_cnt_q} + {1'b0, zeros_s};
      if (stats_clr) begin
         zero_cnt_d = 16'd0;
      end else if (s2_valid_q && out_ready) begin
         zero_cnt_d = sum_s[16] ? 16'hFFFF : sum_s[15:0];
      end else begin
         zero_cnt_d = zero_cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         zero_cnt_q <= 16'd0;
      end else begin
         zero_cnt_q <= zero_cnt_d;
      end
   end

   assign zero_cnt = zero_cnt_q;
`endif

endmodule

// File: tb/tb_relu_stream_act.sv
// Self-checking bench for relu_stream_act: directed spec vectors, random beats against
// an arithmetic reference model, random backpressure, mid-stream reset and optional stats.
module tb_relu_stream_act;
   localparam int DATA_W     = 8;
   localparam int LANES      = 4;
   localparam int LEAK_SHIFT = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [1:0]  mode;
   logic [7:0]  clamp_val;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
`ifdef ACT_STATS_EN
   logic [15:0] zero_cnt;
   logic        stats_clr;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   relu_stream_act #(.DATA_W(DATA_W), .LANES(LANES), .LEAK_SHIFT(LEAK_SHIFT)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .mode      (mode),
      .clamp_val (clamp_val),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef ACT_STATS_EN
      ,
      .zero_cnt  (zero_cnt),
      .stats_clr (stats_clr)
`endif
   );

   // Reference: plain integer arithmetic, floor division for the leaky slope.
   function automatic int ref_lane(input int x, input int m, input int c);
      int div;
      div = 1 << LEAK_SHIFT;
      if (m == 0) return x;
      if (m == 1) return (x < 0) ? 0 : x;
      if (m == 2) return (x < 0) ? -((-x + div - 1) / div) : x;
      if (c < 0) return 0;
      if (x > c) return c;
      if (x < 0) return 0;
      return x;
   endfunction

   function automatic logic [31:0] ref_beat(input logic [31:0] d, input logic [1:0] m, input logic [7:0] c);
      logic [31:0] r;
      logic [7:0]  lane;
      int          x;
      int          y;
      r = 32'd0;
      for (int i = 0; i < LANES; i++) begin
         lane = d[i*8 +: 8];
         x = int'($signed(lane));
         y = ref_lane(x, int'(m), int'($signed(c)));
         r[i*8 +: 8] = y[7:0];
      end
      return r;
   endfunction

   task automatic drive_idle();
      in_valid  = 1'b0;
      in_data   = 32'd0;
      mode      = 2'b00;
      clamp_val = 8'd0;
      out_ready = 1'b1;
`ifdef ACT_STATS_EN
      stats_clr = 1'b0;
`endif
   endtask

   // One beat through an empty pipeline with out_ready=1; checks 2-cycle latency and value.
   task automatic single_beat(input logic [31:0] d, input logic [1:0] m, input logic [7:0] c,
                              input logic [31:0] exp_v, input string name);
      in_valid  = 1'b1;
      in_data   = d;
      mode      = m;
      clamp_val = c;
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s in_ready got %b want 1", name, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s early out_valid got %b want 0", name, out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_v) begin
         errors++;
         $display("FAIL %s out got v=%b %h want v=1 %h", name, out_valid, out_data, exp_v);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      drive_idle();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 32'd0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset got out_valid=%b out_data=%h in_ready=%b want 0 0 1",
                  out_valid, out_data, in_ready);
      end
   endtask

   task automatic test_relu();
      single_beat(32'hFF7F8005, 2'b01, 8'd0, 32'h007F0005, "relu");
   endtask

   task automatic test_leaky();
      single_beat(32'h2880FFF0, 2'b10, 8'd0, 32'h28F0FFFE, "leaky");
   endtask

   task automatic test_clamp();
      single_beat(32'hFB640603, 2'b11, 8'd6,   32'h00060603, "clamp_pos");
      single_beat(32'hFB640603, 2'b11, 8'hFD,  32'h00000000, "clamp_neg");
   endtask

   task automatic test_random_modes();
      logic [31:0] d;
      logic [1:0]  m;
      logic [7:0]  c;
      for (int n = 0; n < 24; n++) begin
         d = $urandom;
         m = 2'(n % 4);
         c = 8'($urandom_range(0, 255));
         single_beat(d, m, c, ref_beat(d, m, c), "random_beat");
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_q[$];
      logic [31:0] exp_v;
      logic        exp_ready;
      logic        in_fire;
      logic        out_fire;
      int          sent;
      int          occ;
      int          cyc;
      sent = 0;
      occ  = 0;
      cyc  = 0;
      in_valid = 1'b0;
      while ((sent < 40 || exp_q.size() > 0) && cyc < 2000) begin
         if (!in_valid && sent < 40) begin
            in_valid  = 1'b1;
            in_data   = $urandom;
            mode      = 2'($urandom_range(0, 3));
            clamp_val = 8'($urandom_range(0, 255));
         end
         out_ready = (cyc < 4) ? 1'b0 : ($urandom_range(0, 2) != 0);
         #1;
         exp_ready = !(occ == 2 && !out_ready);
         checks++;
         if (in_ready !== exp_ready) begin
            errors++;
            $display("FAIL bp_in_ready cyc %0d got %b want %b", cyc, in_ready, exp_ready);
         end
         in_fire  = in_valid && in_ready;
         out_fire = out_valid && out_ready;
         if (out_fire) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL bp_spurious cyc %0d got %h want nothing", cyc, out_data);
            end else begin
               exp_v = exp_q.pop_front();
               if (out_data !== exp_v) begin
                  errors++;
                  $display("FAIL bp_data cyc %0d got %h want %h", cyc, out_data, exp_v);
               end
            end
         end
         if (in_fire) begin
            exp_q.push_back(ref_beat(in_data, mode, clamp_val));
            sent++;
         end
         occ = occ + (in_fire ? 1 : 0) - (out_fire ? 1 : 0);
         @(negedge clk);
         if (in_fire) in_valid = 1'b0;
         cyc++;
      end
      checks++;
      if (sent != 40 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL bp_complete got sent=%0d pending=%0d want 40 0", sent, exp_q.size());
      end
      drive_idle();
      @(negedge clk);
   endtask

   task automatic test_reset_midstream();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h01020304;
      mode      = 2'b00;
      @(negedge clk);
      in_data   = 32'h05060708;
      @(negedge clk);
      in_valid  = 1'b0;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL midreset_full got in_ready=%b out_valid=%b want 0 1", in_ready, out_valid);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_data !== 32'd0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL midreset_clear got v=%b d=%h r=%b want 0 0 1", out_valid, out_data, in_ready);
      end
      reset     = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_stale cycle %0d got out_valid=%b want 0", k, out_valid);
         end
      end
   endtask

`ifdef ACT_STATS_EN
   task automatic stream_beats(input int n, input logic [31:0] d);
      in_valid  = 1'b1;
      in_data   = d;
      mode      = 2'b00;
      out_ready = 1'b1;
      repeat (n) @(negedge clk);
      in_valid  = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_stats();
      logic [31:0] d;
      drive_idle();
      stats_clr = 1'b1;
      @(negedge clk);
      stats_clr = 1'b0;
      checks++;
      if (zero_cnt !== 16'd0) begin
         errors++;
         $display("FAIL stats_clear got %h want 0000", zero_cnt);
      end
      for (int n = 0; n < 3; n++) begin
         d = {8'(-$urandom_range(1, 128)), 8'($urandom_range(1, 127)),
              8'(-$urandom_range(1, 128)), 8'($urandom_range(1, 127))};
         single_beat(d, 2'b01, 8'd0, ref_beat(d, 2'b01, 8'd0), "stats_beat");
      end
      checks++;
      if (zero_cnt !== 16'd6) begin
         errors++;
         $display("FAIL stats_six got %0d want 6", zero_cnt);
      end
      in_valid = 1'b1;
      in_data  = 32'h80FF8181;
      mode     = 2'b01;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      stats_clr = 1'b1;
      @(negedge clk);
      stats_clr = 1'b0;
      checks++;
      if (zero_cnt !== 16'd0) begin
         errors++;
         $display("FAIL stats_clr_wins got %0d want 0", zero_cnt);
      end
      stream_beats(16383, 32'd0);
      checks++;
      if (zero_cnt !== 16'hFFFC) begin
         errors++;
         $display("FAIL stats_near_sat got %h want fffc", zero_cnt);
      end
      stream_beats(1, 32'h00000101);
      checks++;
      if (zero_cnt !== 16'hFFFE) begin
         errors++;
         $display("FAIL stats_fffe got %h want fffe", zero_cnt);
      end
      stream_beats(1, 32'd0);
      checks++;
      if (zero_cnt !== 16'hFFFF) begin
         errors++;
         $display("FAIL stats_saturate got %h want ffff", zero_cnt);
      end
      stream_beats(2, 32'd0);
      checks++;
      if (zero_cnt !== 16'hFFFF) begin
         errors++;
         $display("FAIL stats_stick got %h want ffff", zero_cnt);
      end
   endtask
`endif

   initial begin
      #5000000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      drive_idle();
      @(negedge clk);
      test_reset();
      test_relu();
      test_leaky();
      test_clamp();
      test_random_modes();
      test_back_to_back();
      test_reset_midstream();
`ifdef ACT_STATS_EN
      test_stats();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
